wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges a single-cycle ALU write port and a 2-deep
// buffered LSU port onto one registered register-file write port.
// Ports: clk, rst_n (async, active-low);
//   alu_we/alu_wr/alu_wd in, alu_stall out;
//   lsu_valid/lsu_wr/lsu_wd in, lsu_ready out;
//   rf_we/rf_wr/rf_wd out (registered);
//   q_r1/q_r2 in, q_hit1/q_hit2 out.
// Macro WB_HAZARD_CHECK_EN enables the pending-write query logic.
module wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_we,
  input  logic [4:0]  alu_wr,
  input  logic [31:0] alu_wd,
  output logic        alu_stall,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_wr,
  input  logic [31:0] lsu_wd,
  output logic        rf_we,
  output logic [4:0]  rf_wr,
  output logic [31:0] rf_wd,
  input  logic [4:0]  q_r1,
  input  logic [4:0]  q_r2,
  output logic        q_hit1,
  output logic        q_hit2
);

  localparam int CW =
    (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  // Entry 0 is always the FIFO head.
  logic [4:0]    r_e0_wr;
  logic [31:0]   r_e0_wd;
  logic [4:0]    r_e1_wr;
  logic [31:0]   r_e1_wd;
  logic [1:0]    r_cnt;
  logic [CW-1:0] r_starve;
  logic          r_rf_we;
  logic [4:0]    r_rf_wr;
  logic [31:0]   r_rf_wd;

  logic       w_full;
  logic       w_empty;
  logic       w_stall;
  logic       w_alu_req;
  logic       w_alu_win;
  logic       w_pop;
  logic       w_push;
  logic [1:0] w_rem;

  assign w_full    = (r_cnt == 2'd2);
  assign w_empty   = (r_cnt == 2'd0);
  assign w_stall   = (r_starve == CW'(STARVE_LIMIT))
                   && !w_empty;
  assign w_alu_req = alu_we && (alu_wr != 5'd0);
  assign w_alu_win = w_alu_req && !w_stall;
  assign w_pop     = w_stall || (!w_alu_req && !w_empty);
  // Writes to x0 are accepted but never stored.
  assign w_push    = lsu_valid && !w_full
                   && (lsu_wr != 5'd0);
  // Entries left after this cycle's pop; a push lands here.
  assign w_rem     = r_cnt - {1'b0, w_pop};

  assign alu_stall = w_stall;
  assign lsu_ready = !w_full;
  assign rf_we     = r_rf_we;
  assign rf_wr     = r_rf_wr;
  assign rf_wd     = r_rf_wd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e0_wr  <= '0;
      r_e0_wd  <= '0;
      r_e1_wr  <= '0;
      r_e1_wd  <= '0;
      r_cnt    <= '0;
      r_starve <= '0;
      r_rf_we  <= 1'b0;
      r_rf_wr  <= '0;
      r_rf_wd  <= '0;
    end else begin
      if (w_pop) begin
        r_rf_we <= 1'b1;
        r_rf_wr <= r_e0_wr;
        r_rf_wd <= r_e0_wd;
      end else if (w_alu_win) begin
        r_rf_we <= 1'b1;
        r_rf_wr <= alu_wr;
        r_rf_wd <= alu_wd;
      end else begin
        r_rf_we <= 1'b0;
      end

      if (w_pop) begin
        r_e0_wr <= r_e1_wr;
        r_e0_wd <= r_e1_wd;
      end
      // Later assignment overrides the shift when the FIFO drains to 0.
      if (w_push) begin
        if (w_rem == 2'd0) begin
          r_e0_wr <= lsu_wr;
          r_e0_wd <= lsu_wd;
        end else begin
          r_e1_wr <= lsu_wr;
          r_e1_wd <= lsu_wd;
        end
      end
      r_cnt <= w_rem + {1'b0, w_push};

      if (w_pop || w_empty) begin
        r_starve <= '0;
      end else if (w_alu_win) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end

`ifdef WB_HAZARD_CHECK_EN
  function automatic logic hit(input logic [4:0] q);
    logic h;
    h = 1'b0;
    if (r_cnt != 2'd0 && r_e0_wr == q) h = 1'b1;
    if (r_cnt == 2'd2 && r_e1_wr == q) h = 1'b1;
    if (r_rf_we && r_rf_wr == q)        h = 1'b1;
    return h && (q != 5'd0);
  endfunction

  assign q_hit1 = hit(q_r1);
  assign q_hit2 = hit(q_r2);
`else
  logic w_unused_q;
  assign w_unused_q = ^{q_r1, q_r2};
  assign q_hit1 = 1'b0;
  assign q_hit2 = 1'b0;
`endif

endmodule
